l1a_dly_line: RTL
=================

# l1a_dly_line

Programmable L1A latency delay line for the CFEB trigger path. It sits directly downstream of the JTAG user-register block and consumes its extra-L1A-delay setting (XL1DLYSET) and the 12.5 µs latency mode bit (LAT_12_5US). It delays every incoming L1A by a latency that is fixed at the moment the L1A arrives. It holds up to DEPTH outstanding L1As and delivers them in order as single-cycle pulses with a running sequence number.

## Interface
Parameters:
- BASE_DLY, 100: base latency in CLK cycles; legal range 2..(1023−48−LONG_ADD).
- STEP_DLY, 16: cycles added per XL1DLYSET count; fixed at 16.
- LONG_ADD, 400: cycles added when LAT_12_5US=1.
- DEPTH, 8: number of outstanding L1As; power of two, 2..16.

Ports:
- CLK, in, 1: 40 MHz system clock; the only clock.
- RST, in, 1: synchronous, active-high reset.
- L1A, in, 1: L1A strobe; each high cycle is one L1A.
- XL1DLYSET, in, 2: extra-delay select from the JTAG register.
- LAT_12_5US, in, 1: long-latency mode from the cfeb_config register.
- L1A_DLY, out, 1: delayed L1A, one-cycle pulse.
- L1A_SEQ, out, 4: sequence number of the current L1A_DLY pulse; valid only while L1A_DLY=1.
- PENDING, out, log2(DEPTH)+1: number of L1As currently queued.
- OVF, out, 1: sticky flag, set when an L1A is dropped.

## Operation
- Latency: D = BASE_DLY + 16·XL1DLYSET + (LAT_12_5US ? LONG_ADD : 0).
- D is evaluated in the cycle L1A is sampled. Later changes to XL1DLYSET or LAT_12_5US do not affect L1As already queued.
- Free-running 10-bit timestamp counter `ts`, wrapping modulo 1024.
- On an accepted L1A, push target = (ts + D) mod 1024 into a DEPTH-entry circular FIFO.
- Pop the head entry when `ts` equals the head target. The pop produces an L1A_DLY pulse with L1A_SEQ equal to the current sequence counter, which then increments by 1 mod 16.
- Ordering holds because D is bounded at 1023 and entries are pushed in time order. Wrap-around comparison is an exact match only; no magnitude compare.
- Push and pop in the same cycle: both occur, and PENDING is unchanged.
- Full (PENDING=DEPTH) and L1A with no pop that cycle: the L1A is dropped and OVF is set. If a pop occurs in the same cycle, the L1A is accepted.
- L1A in consecutive cycles: every one is accepted while the FIFO has room, and the outputs appear in consecutive cycles.
- OVF is cleared only by RST.
- RST mid-operation flushes all pending L1As. No L1A_DLY is generated for them.

## Timing
- An L1A sampled high at rising edge k produces L1A_DLY high during the cycle after edge k+D, i.e. exactly D cycles later. L1A_DLY is a registered output.
- PENDING updates on the edge following the push or pop.
- Reset values: L1A_DLY=0, L1A_SEQ=0, PENDING=0, OVF=0, ts=0, sequence counter=0, FIFO pointers=0.
- The first L1A sampled at the edge where RST deasserts is ignored. L1As are accepted from the next edge.
- Minimum D=2 must work, including back-to-back L1As.

## Configuration
- Macro L1A_DLY_SEQCHK_EN.
- Defined:
  - Adds output SEQERR (1 bit, reset 0).
  - SEQERR pulses for one cycle if a pop occurs whose head target does not equal ts. This is an internal consistency check and never fires in correct operation.
  - Adds a 16-bit saturating count of dropped L1As, readable as output DROPCNT. DROPCNT resets to 0 and saturates at 0xFFFF.
- Undefined: the SEQERR and DROPCNT ports and their logic are absent. All other behaviour is identical.

## Test plan
- Defaults, XL1DLYSET=01, LAT_12_5US=0, single L1A at cycle 10 → L1A_DLY at cycle 126 (D=116), L1A_SEQ=0, PENDING 1 then 0.
- XL1DLYSET=11, LAT_12_5US=1 (D=548), L1A at cycle 1000 (ts wraps) → L1A_DLY at cycle 1548. No spurious pulse at cycle 1000+548−1024.
- L1A at cycle 20 with XL1DLYSET=00, switch to 11 at cycle 21, L1A at cycle 22 → pulses at 120 and 170, L1A_SEQ 0 then 1.
- DEPTH=8, 10 consecutive L1As → 8 outputs in consecutive cycles, OVF=1 from the 9th L1A, PENDING peaks at 8. With L1A_DLY_SEQCHK_EN defined, DROPCNT=2.
- Queue full and the head pops in the same cycle as a new L1A → new L1A accepted, OVF stays 0, PENDING stays 8.
- Queue 3 L1As, assert RST for 1 cycle before any matures → no L1A_DLY, PENDING=0, L1A_SEQ=0, next L1A delivered with L1A_SEQ=0.

Source files
------------

// File: rtl/l1a_dly_line.sv
// Purpose: programmable L1A latency line; each L1A re-emerges as a one-cycle pulse with a 4-bit sequence number.
// Latency: D = BASE_DLY + STEP_DLY*XL1DLYSET + (LAT_12_5US ? LONG_ADD : 0) cycles, fixed when the L1A is sampled.
// Backpressure: none upstream; up to DEPTH L1As outstanding, extra L1As are dropped and flagged on sticky OVF.
// Optional feature macro: L1A_DLY_SEQCHK_EN adds SEQERR (consistency pulse) and DROPCNT (saturating drop count).
module l1a_dly_line #(
    parameter int BASE_DLY = 100,
    parameter int STEP_DLY = 16,
    parameter int LONG_ADD = 400,
    parameter int DEPTH    = 8,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          L1A,
    input  logic [1:0]    XL1DLYSET,
    input  logic          LAT_12_5US,
    output logic          L1A_DLY,
    output logic [3:0]    L1A_SEQ,
    output logic [AW:0]   PENDING,
    output logic          OVF
`ifdef L1A_DLY_SEQCHK_EN
    ,
    output logic          SEQERR,
    output logic [15:0]   DROPCNT
`endif
);

    // Free-running timestamp; all targets live in this 10-bit modulo space.
    logic [9:0]    ts;

    // Target-timestamp ring buffer; pointers wrap for free because DEPTH is a power of two.
    logic [9:0]    tgt_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [3:0]    seq_cnt;

    logic [9:0]    dly;
    logic [9:0]    head_tgt;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    // Latency for an L1A arriving this cycle and the push/pop/drop decisions.
    always_comb begin
        dly      = 10'(BASE_DLY)
                 + 10'(STEP_DLY) * {8'd0, XL1DLYSET}
                 + (LAT_12_5US ? 10'(LONG_ADD) : 10'd0);
        head_tgt = tgt_mem[rd_ptr];
        full     = (count == (AW+1)'(DEPTH));
        // Exact-match compare only: targets are pushed in time order and D < 1024,
        // so the head is always the next one to mature.
        pop      = (count != '0) && (head_tgt == ts);
        // A pop frees a slot in the same cycle, so a full queue still accepts then.
        push     = L1A && (!full || pop);
        drop     = L1A && full && !pop;
    end

    // Timestamp counter, wraps modulo 1024.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ts <= '0;
        end else begin
            ts <= ts + 10'd1;
        end
    end

    // Store the maturity time of each accepted L1A; contents need no reset since pointers gate them.
    always_ff @(posedge CLK) begin
        if (push) begin
            tgt_mem[wr_ptr] <= ts + dly;
        end
    end

    // Queue pointers and occupancy; reset flushes everything outstanding.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered delayed-L1A pulse with its sequence number; sequence advances per delivered pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            L1A_DLY <= 1'b0;
            L1A_SEQ <= 4'd0;
            seq_cnt <= 4'd0;
        end else begin
            L1A_DLY <= pop;
            if (pop) begin
                L1A_SEQ <= seq_cnt;
                seq_cnt <= seq_cnt + 4'd1;
            end
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OVF <= 1'b0;
        end else if (drop) begin
            OVF <= 1'b1;
        end
    end

    assign PENDING = count;

`ifdef L1A_DLY_SEQCHK_EN
    logic seq_err_nxt;

    // A pop must only ever happen on a non-empty queue whose head target equals ts.
    always_comb begin
        seq_err_nxt = pop && ((head_tgt != ts) || (count == '0));
    end

    // Consistency pulse and saturating count of dropped L1As.
    always_ff @(posedge CLK) begin
        if (RST) begin
            SEQERR  <= 1'b0;
            DROPCNT <= 16'd0;
        end else begin
            SEQERR <= seq_err_nxt;
            if (drop && (DROPCNT != 16'hFFFF)) begin
                DROPCNT <= DROPCNT + 16'd1;
            end
        end
    end
`endif

endmodule
